// File: rtl/uart_rx_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// master = receiver side, slave = downstream consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  uart_rx_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_pend;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;
  logic                   r_busy;
  logic                   w_rxd_s;
  logic                   w_tc;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_ok;
  logic                   r_perr_pend;
  logic                   r_perr;
`endif

  assign w_rxd_s = r_sync[SYNC_STAGES-1];
  assign w_tc    = (r_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync  <= '1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_pend  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok    <= 1'b0;
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
      r_pend <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_pend <= 1'b0;
      r_perr      <= r_perr_pend;
`endif

      // Delivery runs one cycle after the stop sample; r_shift is still intact
      // because the next frame cannot reach DATA that quickly.
      if (r_pend) begin
        if (!r_valid || bus.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= HALF_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tc) begin
            if (!w_rxd_s) begin
              r_state <= S_DATA;
              r_cnt   <= FULL_LOAD;
              r_bit   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (w_tc) begin
            r_shift[r_bit] <= w_rxd_s;
            r_cnt          <= FULL_LOAD;
            r_bit          <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tc) begin
            r_par_ok <= ~(^{r_shift, w_rxd_s});
            r_cnt    <= FULL_LOAD;
            r_state  <= S_STOP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_tc) begin
            if (w_rxd_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_pend      <= r_par_ok;
              r_perr_pend <= ~r_par_ok;
`else
              r_pend <= 1'b1;
`endif
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_BREAK: begin
          if (w_rxd_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, expected bytes
// and error-pulse counts are queued by the stimulus and checked by a monitor.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic rxd    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rxd    (rxd),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int fe_edges = 0, fe_cyc = 0, ov_edges = 0, ov_cyc = 0, pe_edges = 0, pe_cyc = 0;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_pe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 3 time units after the rising edge; the monitor samples on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d));
    send_bit(1'b1);
  endtask
`endif

  always @(negedge clk) begin
    logic [7:0] e;
    if (resetn) begin
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, e});
        end
      end
      if (bus.frame_err) begin fe_cyc++; if (!prev_fe) fe_edges++; end
      if (bus.overrun)    begin ov_cyc++; if (!prev_ov) ov_edges++; end
      if (bus.parity_err) begin pe_cyc++; if (!prev_pe) pe_edges++; end
    end
    prev_fe = bus.frame_err;
    prev_ov = bus.overrun;
    prev_pe = bus.parity_err;
  end

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"}, fe_edges, exp_fe);
    check({tag, "_overrun"}, ov_edges, exp_ov);
    check({tag, "_parity_err"}, pe_edges, exp_pe);
  endtask

  initial begin
    logic [7:0] d;
    bus.rx_ready = 1'b1;
    resetn = 1'b0;
    rxd    = 1'b1;
    tick(3);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'h0);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'h0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'h0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'h0);
    check("rst_parity_err", {31'd0, bus.parity_err}, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, 32'h0);
    resetn = 1'b1;
    tick(5);

    // Single frame, consumer always ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("t1_busy_after_stop", {31'd0, bus.busy}, 32'h0);
    tick(2);
    check("t1_delivered", exp_q.size(), 0);
    check_counts("t1");

    // Consumer stalled across two back-to-back frames: second one overruns.
    bus.rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    exp_ov++;
    tick(4);
    check("t2_valid_held", {31'd0, bus.rx_valid}, 32'h1);
    check("t2_data_held", {24'd0, bus.rx_data}, 32'h3C);
    check_counts("t2");
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_valid_drop", {31'd0, bus.rx_valid}, 32'h0);
    #2;
    tick(2);

    // Short low glitch on an idle line.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    check("t3_busy_idle", {31'd0, bus.busy}, 32'h0);
    check_counts("t3");

    // Stop bit 0 followed by a held-low line, then a good frame.
    send_frame(8'h55, 1'b0);
    exp_fe++;
    tick(40);
    check("t4_busy_break", {31'd0, bus.busy}, 32'h1);
    rxd = 1'b1;
    tick(5);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(4);
    check_counts("t4");

    // Reset in the middle of the data bits of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    resetn = 1'b0;
    #1;
    check("t5_rst_rx_data", {24'd0, bus.rx_data}, 32'h0);
    check("t5_rst_rx_valid", {31'd0, bus.rx_valid}, 32'h0);
    check("t5_rst_busy", {31'd0, bus.busy}, 32'h0);
    check("t5_rst_flags", {29'd0, bus.frame_err, bus.overrun, bus.parity_err}, 32'h0);
    tick(3);
    resetn = 1'b1;
    tick(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(4);
    check_counts("t5");

    // Random bytes with random idle gaps (zero gap means back-to-back).
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, 1'b1);
      tick(int'($urandom_range(0, 20)));
    end

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    send_frame_badpar(8'h07);
    exp_pe++;
    tick(4);
`endif

    for (int t = 0; t < 200 && exp_q.size() > 0; t++) tick(1);
    check("drain_queue_empty", exp_q.size(), 0);
    check_counts("final");
    check("frame_err_width", fe_cyc, fe_edges);
    check("overrun_width", ov_cyc, ov_edges);
    check("parity_err_width", pe_cyc, pe_edges);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
